axi2apb_bridge: RTL and testbench
=================================

Name: axi2apb_bridge

Overview:
- Bridge from one AXI3 slave port to an APB3 master port with two one-hot slave selects.
- Converts every beat of an AXI write or read burst into one APB SETUP/ACCESS transfer.
- Returns B and R responses to the AXI master.
- Processes one burst at a time and sits between the system AXI interconnect and the peripheral APB segment.

Parameters:
- ADDR_WIDTH, 32, AXI/APB address width.
- DATA_WIDTH, 32, AXI/APB data width; one beat is one 4-byte word.
- ID_WIDTH, 4, AXI ID width.
- SLV0_BASE, 32'h0001_F000, base of the APB slave 0 region.
- SLV1_BASE, 32'h0002_F000, base of the APB slave 1 region.
- SLV_SIZE, 32'h0000_1000, size of each region (4 KB).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- awid_i in ID_WIDTH; awaddr_i in ADDR_WIDTH; awlen_i in 4 (beats-1); awsize_i in 3; awburst_i in 2; awvalid_i in 1; awready_o out 1.
- wid_i in ID_WIDTH; wdata_i in DATA_WIDTH; wstrb_i in DATA_WIDTH/8; wlast_i in 1; wvalid_i in 1; wready_o out 1.
- bid_o out ID_WIDTH; bresp_o out 2; bvalid_o out 1; bready_i in 1.
- arid_i in ID_WIDTH; araddr_i in ADDR_WIDTH; arlen_i in 4; arsize_i in 3; arburst_i in 2; arvalid_i in 1; arready_o out 1.
- rid_o out ID_WIDTH; rdata_o out DATA_WIDTH; rresp_o out 2; rlast_o out 1; rvalid_o out 1; rready_i in 1.
- paddr_o out ADDR_WIDTH; pwdata_o out DATA_WIDTH; pwrite_o out 1; penable_o out 1; psel_o out 2 (one-hot); prdata_i in DATA_WIDTH; pready_i in 1; pslverr_i in 1.

Behaviour:
- Reset: all outputs are 0, i.e. every valid/ready, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, rdata_o, rlast_o, bresp_o, rresp_o, bid_o and rid_o. The FSM goes to IDLE.
- Reset mid-burst aborts immediately; no B or R response is issued for the aborted burst.
- FSM states: IDLE, W_DATA, W_SETUP, W_ACCESS, B_RESP, R_SETUP, R_ACCESS, R_DATA.
- IDLE:
  - awready_o=1 and arready_o=1 are driven combinationally, but only one channel is granted per cycle; write has priority.
  - On awvalid_i, latch id, addr, len and burst, clear the beat counter and error flag, then go to W_DATA.
  - Otherwise, on arvalid_i, latch the AR fields and go to R_SETUP.
- W_DATA: wready_o=1. On wvalid_i, latch wdata_i into pwdata_o and go to W_SETUP.
- SETUP states: psel_o asserts the decoded bit, penable_o=0, paddr_o = current address, pwrite_o = 1 for write and 0 for read.
- ACCESS states: same as SETUP plus penable_o=1. Stay until pready_i.
  - APB signals are stable from SETUP through ACCESS.
  - psel_o and penable_o drop to 0 the cycle after pready_i.
- Write beat completion (pready_i in W_ACCESS):
  - OR pslverr_i into the error flag.
  - If beat == len, go to B_RESP; else beat++, advance the address, go to W_DATA.
- B_RESP: bvalid_o=1, bid_o = latched id, bresp_o = OKAY(00), SLVERR(10) if any beat erred, or DECERR(11). Hold until bready_i, then go to IDLE.
- Read beat completion (pready_i in R_ACCESS): register prdata_i into rdata_o, rresp_o = pslverr_i ? SLVERR : OKAY, then go to R_DATA.
- R_DATA: rvalid_o=1, rid_o = id, rlast_o = (beat == len). Hold until rready_i, then go to IDLE if last, else beat++, advance the address, go to R_SETUP.
- Addressing:
  - FIXED (00): address unchanged for every beat.
  - INCR (01): address += 4 per beat.
  - WRAP (10) and reserved (11) are treated as INCR.
  - awsize and arsize are ignored; every beat is 32-bit.
  - FIXED read returns data at the same address each beat; FIXED write leaves the last beat's data in place.
- Decode: addr in [SLV0_BASE, SLV0_BASE+SLV_SIZE) selects psel_o=01; addr in [SLV1_BASE, SLV1_BASE+SLV_SIZE) selects psel_o=10. Never 11.
- Unmapped beat: no APB transfer, psel_o stays 00.
  - Write: the W beat is still accepted, and the response is DECERR.
  - Read: the beat returns rdata_o=0 with DECERR.
- Ignored inputs: wstrb_i (full-word writes only), wid_i, and wlast_i (awlen_i is authoritative).
- Latency: minimum 3 cycles per write beat (W accept, SETUP, ACCESS) and 3 cycles per read beat (SETUP, ACCESS, R valid), plus pready_i wait states.

Decomposition:
- Package axi2apb_pkg holds:
  - burst encodings FIXED/INCR/WRAP;
  - response codes OKAY/SLVERR/DECERR;
  - state enum;
  - default region base and size constants.
- One natural sub-module, axi2apb_decoder: combinational address to one-hot psel and a hit flag.

Test Plan:
- INCR write of 16 beats to 0x0001_F100 with data D0..D15 -> 16 APB writes at 0x1F100..0x1F13C with psel_o=01, bresp=OKAY; a 16-beat INCR read returns D0..D15 with rlast_o only on beat 16.
- FIXED write of 4 beats to 0x0002_F200 -> 4 APB writes all at 0x2F200 with psel_o=10; a 4-beat FIXED read returns D3 on all four beats.
- Single beat with pready_i held low 3 cycles -> penable_o stays high 4 cycles and paddr/pwdata stay stable; read data is captured only on the pready_i cycle.
- pslverr_i=1 on beat 2 of a 3-beat write -> bresp=10; on a read, rresp=10 for that beat only.
- Write to 0x0003_0000 -> psel_o stays 00 and bresp=11; read there -> rdata=0, rresp=11. psel_o never equals 11.
- awvalid_i and arvalid_i both high in IDLE -> write completes (B handshake) before AR is accepted. rst high mid-R_ACCESS -> all outputs 0 next cycle.

Source files
------------

// File: rtl/axi2apb_pkg.sv
// Shared definitions for the AXI3 -> APB3 bridge.
//   - AXI burst encodings and response codes
//   - bridge FSM state enum
//   - default APB region map (two 4 KB slave windows)
package axi2apb_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_SLV0_BASE = 32'h0001_F000;
  localparam logic [31:0] DEF_SLV1_BASE = 32'h0002_F000;
  localparam logic [31:0] DEF_SLV_SIZE  = 32'h0000_1000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_DATA   = 3'd1,
    ST_W_SETUP  = 3'd2,
    ST_W_ACCESS = 3'd3,
    ST_B_RESP   = 3'd4,
    ST_R_SETUP  = 3'd5,
    ST_R_ACCESS = 3'd6,
    ST_R_DATA   = 3'd7
  } state_e;

endpackage

// File: rtl/axi2apb_bridge_decoder.sv
// Combinational APB address decoder.
// Ports:
//   i_addr  - current beat address
//   o_psel  - one-hot slave select (01 = slave 0, 10 = slave 1, 00 = unmapped)
//   o_hit   - address falls inside one of the two slave windows
module axi2apb_decoder
  import axi2apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] SLV0_BASE  = ADDR_WIDTH'(DEF_SLV0_BASE),
  parameter logic [ADDR_WIDTH-1:0] SLV1_BASE  = ADDR_WIDTH'(DEF_SLV1_BASE),
  parameter logic [ADDR_WIDTH-1:0] SLV_SIZE   = ADDR_WIDTH'(DEF_SLV_SIZE)
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [1:0]            o_psel,
  output logic                  o_hit
);

  // One extra bit so base+size cannot wrap at the top of the address space.
  logic [ADDR_WIDTH:0] w_addr;
  logic [ADDR_WIDTH:0] w_s0_lo, w_s0_hi, w_s1_lo, w_s1_hi;
  logic                w_in0, w_in1;

  assign w_addr  = {1'b0, i_addr};
  assign w_s0_lo = {1'b0, SLV0_BASE};
  assign w_s0_hi = {1'b0, SLV0_BASE} + {1'b0, SLV_SIZE};
  assign w_s1_lo = {1'b0, SLV1_BASE};
  assign w_s1_hi = {1'b0, SLV1_BASE} + {1'b0, SLV_SIZE};

  assign w_in0 = (w_addr >= w_s0_lo) && (w_addr < w_s0_hi);
  assign w_in1 = (w_addr >= w_s1_lo) && (w_addr < w_s1_hi);

  // Slave 0 wins if the windows were ever configured to overlap, so the
  // select can never become 11.
  always_comb begin
    o_psel = 2'b00;
    if (w_in0)      o_psel = 2'b01;
    else if (w_in1) o_psel = 2'b10;
  end

  assign o_hit = |o_psel;

endmodule

// File: rtl/axi2apb_bridge.sv
// AXI3 slave -> APB3 master bridge, one burst at a time.
// Every AXI beat becomes one APB SETUP/ACCESS transfer; B and R responses
// are returned to the AXI master.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   aw*/w*/b*          - AXI write address, data and response channels
//   ar*/r*             - AXI read address and data channels
//   p*                 - APB3 master, psel_o one-hot over two slaves
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for AW (priority) or AR
// W_DATA      | waiting for the W beat of the current write
// W_SETUP     | APB write SETUP phase (or DECERR skip if unmapped)
// W_ACCESS    | APB write ACCESS phase, waiting for pready_i
// B_RESP      | write response valid, waiting for bready_i
// R_SETUP     | APB read SETUP phase (or DECERR skip if unmapped)
// R_ACCESS    | APB read ACCESS phase, waiting for pready_i
// R_DATA      | read beat valid, waiting for rready_i
module axi2apb_bridge
  import axi2apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] SLV0_BASE  = ADDR_WIDTH'(DEF_SLV0_BASE),
  parameter logic [ADDR_WIDTH-1:0] SLV1_BASE  = ADDR_WIDTH'(DEF_SLV1_BASE),
  parameter logic [ADDR_WIDTH-1:0] SLV_SIZE   = ADDR_WIDTH'(DEF_SLV_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic [3:0]              awlen_i,
  input  logic [2:0]              awsize_i,
  input  logic [1:0]              awburst_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ID_WIDTH-1:0]     wid_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wlast_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [ID_WIDTH-1:0]     bid_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ID_WIDTH-1:0]     arid_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic [3:0]              arlen_i,
  input  logic [2:0]              arsize_i,
  input  logic [1:0]              arburst_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [ID_WIDTH-1:0]     rid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic                    pwrite_o,
  output logic                    penable_o,
  output logic [1:0]              psel_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [ID_WIDTH-1:0]     r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [3:0]              r_len;
  logic [1:0]              r_burst;
  logic [3:0]              r_beat;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]              r_rresp;
  logic                    r_slverr;
  logic                    r_decerr;

  logic                    w_ld_aw, w_ld_ar, w_ld_w, w_adv;
  logic                    w_set_slverr, w_set_decerr, w_rd_cap, w_rd_dec;
  logic                    w_last, w_hit;
  logic [1:0]              w_psel;
  logic [ADDR_WIDTH-1:0]   w_next_addr;

  // Size, strobes, W id and WLAST carry no information for this bridge:
  // beats are always full words and awlen_i sets the beat count.
  logic w_unused;
  assign w_unused = ^{awsize_i, arsize_i, wid_i, wstrb_i, wlast_i};

  axi2apb_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV0_BASE  (SLV0_BASE),
    .SLV1_BASE  (SLV1_BASE),
    .SLV_SIZE   (SLV_SIZE)
  ) u_decoder (
    .i_addr (r_addr),
    .o_psel (w_psel),
    .o_hit  (w_hit)
  );

  assign w_last = (r_beat == r_len);

  always_comb begin
    case (r_burst)
      BURST_FIXED:            w_next_addr = r_addr;
      BURST_INCR, BURST_WRAP: w_next_addr = r_addr + ADDR_WIDTH'(4);
      default:                w_next_addr = r_addr + ADDR_WIDTH'(4);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_aw      = 1'b0;
    w_ld_ar      = 1'b0;
    w_ld_w       = 1'b0;
    w_adv        = 1'b0;
    w_set_slverr = 1'b0;
    w_set_decerr = 1'b0;
    w_rd_cap     = 1'b0;
    w_rd_dec     = 1'b0;
    awready_o    = 1'b0;
    arready_o    = 1'b0;
    wready_o     = 1'b0;
    bvalid_o     = 1'b0;
    rvalid_o     = 1'b0;
    rlast_o      = 1'b0;
    psel_o       = 2'b00;
    penable_o    = 1'b0;
    pwrite_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Ready is masked while rst is high so every output reads 0 in reset.
        // AR ready is withheld whenever AW is pending so the master never
        // sees an AR handshake that the write grant would discard.
        awready_o = ~rst;
        arready_o = ~rst & ~awvalid_i;
        if (awvalid_i) begin
          w_ld_aw     = 1'b1;
          w_state_nxt = ST_W_DATA;
        end else if (arvalid_i) begin
          w_ld_ar     = 1'b1;
          w_state_nxt = ST_R_SETUP;
        end
      end
      ST_W_DATA: begin
        wready_o = 1'b1;
        if (wvalid_i) begin
          w_ld_w      = 1'b1;
          w_state_nxt = ST_W_SETUP;
        end
      end
      ST_W_SETUP: begin
        psel_o   = w_psel;
        pwrite_o = 1'b1;
        if (w_hit) begin
          w_state_nxt = ST_W_ACCESS;
        end else begin
          // Unmapped beat: consumed without an APB transfer.
          w_set_decerr = 1'b1;
          if (w_last) begin
            w_state_nxt = ST_B_RESP;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = ST_W_DATA;
          end
        end
      end
      ST_W_ACCESS: begin
        psel_o    = w_psel;
        penable_o = 1'b1;
        pwrite_o  = 1'b1;
        if (pready_i) begin
          w_set_slverr = pslverr_i;
          if (w_last) begin
            w_state_nxt = ST_B_RESP;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = ST_W_DATA;
          end
        end
      end
      ST_B_RESP: begin
        bvalid_o = 1'b1;
        if (bready_i) w_state_nxt = ST_IDLE;
      end
      ST_R_SETUP: begin
        psel_o = w_psel;
        if (w_hit) begin
          w_state_nxt = ST_R_ACCESS;
        end else begin
          w_rd_dec    = 1'b1;
          w_state_nxt = ST_R_DATA;
        end
      end
      ST_R_ACCESS: begin
        psel_o    = w_psel;
        penable_o = 1'b1;
        if (pready_i) begin
          w_rd_cap    = 1'b1;
          w_state_nxt = ST_R_DATA;
        end
      end
      ST_R_DATA: begin
        rvalid_o = 1'b1;
        rlast_o  = w_last;
        if (rready_i) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = ST_R_SETUP;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_burst  <= '0;
      r_beat   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
      r_slverr <= 1'b0;
      r_decerr <= 1'b0;
    end else begin
      if (w_ld_aw) begin
        r_id     <= awid_i;
        r_addr   <= awaddr_i;
        r_len    <= awlen_i;
        r_burst  <= awburst_i;
        r_beat   <= '0;
        r_slverr <= 1'b0;
        r_decerr <= 1'b0;
      end else if (w_ld_ar) begin
        r_id     <= arid_i;
        r_addr   <= araddr_i;
        r_len    <= arlen_i;
        r_burst  <= arburst_i;
        r_beat   <= '0;
        r_slverr <= 1'b0;
        r_decerr <= 1'b0;
      end
      if (w_ld_w) r_wdata <= wdata_i;
      if (w_adv) begin
        r_beat <= r_beat + 4'd1;
        r_addr <= w_next_addr;
      end
      if (w_set_slverr) r_slverr <= 1'b1;
      if (w_set_decerr) r_decerr <= 1'b1;
      if (w_rd_cap) begin
        r_rdata <= prdata_i;
        r_rresp <= pslverr_i ? RESP_SLVERR : RESP_OKAY;
      end
      if (w_rd_dec) begin
        r_rdata <= '0;
        r_rresp <= RESP_DECERR;
      end
    end
  end

  // A decode miss outranks a slave error when a burst has both.
  assign bresp_o  = r_decerr ? RESP_DECERR : (r_slverr ? RESP_SLVERR : RESP_OKAY);
  assign bid_o    = r_id;
  assign rid_o    = r_id;
  assign rdata_o  = r_rdata;
  assign rresp_o  = r_rresp;
  assign paddr_o  = r_addr;
  assign pwdata_o = r_wdata;

endmodule

// File: tb/tb_axi2apb_bridge.sv
module tb_axi2apb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid_i = '0;
  logic [31:0] awaddr_i = '0;
  logic [3:0]  awlen_i = '0;
  logic [2:0]  awsize_i = '0;
  logic [1:0]  awburst_i = '0;
  logic        awvalid_i = 1'b0;
  logic        awready_o;
  logic [3:0]  wid_i = '0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  wstrb_i = '0;
  logic        wlast_i = 1'b0;
  logic        wvalid_i = 1'b0;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i = 1'b0;
  logic [3:0]  arid_i = '0;
  logic [31:0] araddr_i = '0;
  logic [3:0]  arlen_i = '0;
  logic [2:0]  arsize_i = '0;
  logic [1:0]  arburst_i = '0;
  logic        arvalid_i = 1'b0;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i = 1'b0;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        penable_o;
  logic [1:0]  psel_o;
  logic [31:0] prdata_i = 32'hDEAD_BEEF;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  axi2apb_bridge dut (
    .clk(clk), .rst(rst),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o), .penable_o(penable_o),
    .psel_o(psel_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  logic [117:0] all_outs;
  assign all_outs = {awready_o, wready_o, arready_o, bvalid_o, bid_o, bresp_o, rvalid_o,
                     rid_o, rdata_o, rresp_o, rlast_o, paddr_o, pwdata_o, pwrite_o,
                     penable_o, psel_o};

  // ---------------- APB slave model ----------------
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          err_at = -1;
  int          xfer_n = 0;
  int          pen_cnt = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] setup_addr = '0, setup_data = '0;
  logic        stable = 1'b1;
  logic        sel_seen = 1'b0;
  logic        sel11_seen = 1'b0;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wr[$];
  logic [1:0]  log_sel[$];
  int          log_pen[$];
  logic        log_stable[$];

  always @(negedge clk) begin
    if (psel_o == 2'b11) sel11_seen = 1'b1;
    if (psel_o != 2'b00) sel_seen = 1'b1;
    if (psel_o != 2'b00 && !penable_o) begin
      setup_addr = paddr_o;
      setup_data = pwdata_o;
      pen_cnt    = 0;
      stable     = 1'b1;
    end
    if (psel_o != 2'b00 && penable_o) begin
      pen_cnt++;
      if (paddr_o !== setup_addr || pwdata_o !== setup_data) stable = 1'b0;
      if (wait_cnt < wait_cfg) begin
        wait_cnt++;
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        prdata_i  = 32'hDEAD_BEEF;
      end else begin
        pready_i  = 1'b1;
        pslverr_i = (xfer_n == err_at);
        prdata_i  = pwrite_o ? 32'hDEAD_BEEF : (mem.exists(paddr_o) ? mem[paddr_o] : 32'h0);
      end
    end else begin
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      prdata_i  = 32'hDEAD_BEEF;
      wait_cnt  = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && psel_o != 2'b00 && penable_o && pready_i) begin
      log_addr.push_back(paddr_o);
      log_data.push_back(pwdata_o);
      log_wr.push_back(pwrite_o);
      log_sel.push_back(psel_o);
      log_pen.push_back(pen_cnt);
      log_stable.push_back(stable);
      if (pwrite_o) mem[paddr_o] = pwdata_o;
      xfer_n++;
    end
  end

  // ---------------- helpers ----------------
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];

  function automatic logic [31:0] dpat(input logic [31:0] base, input int k);
    return base + 32'(k) * 32'h0000_0111;
  endfunction

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_wr.delete();
    log_sel.delete();  log_pen.delete();  log_stable.delete();
    xfer_n   = 0;
    sel_seen = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [31:0] d0,
                          output logic [1:0] resp, output logic [3:0] bid);
    int g;
    awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awsize_i = 3'd2;
    awvalid_i = 1'b1;
    g = 0;
    while (!awready_o && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin n_checks++; $display("FAIL aw_timeout addr=%h", addr); end
    @(negedge clk);
    awvalid_i = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wdata_i = dpat(d0, k); wstrb_i = 4'hF; wid_i = id; wlast_i = (k == int'(len));
      wvalid_i = 1'b1;
      g = 0;
      while (!wready_o && g < 200) begin @(negedge clk); g++; end
      if (g >= 200) begin n_checks++; $display("FAIL w_timeout beat=%0d", k); end
      @(negedge clk);
      wvalid_i = 1'b0;
    end
    bready_i = 1'b1;
    g = 0;
    while (!bvalid_o && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin n_checks++; $display("FAIL b_timeout addr=%h", addr); end
    resp = bresp_o;
    bid  = bid_o;
    @(negedge clk);
    bready_i = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    int g;
    arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst; arsize_i = 3'd2;
    arvalid_i = 1'b1;
    g = 0;
    while (!arready_o && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) begin n_checks++; $display("FAIL ar_timeout addr=%h", addr); end
    @(negedge clk);
    arvalid_i = 1'b0;
    rready_i  = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      g = 0;
      while (!rvalid_o && g < 200) begin @(negedge clk); g++; end
      if (g >= 200) begin n_checks++; $display("FAIL r_timeout beat=%0d", k); end
      rd_data[k] = rdata_o; rd_resp[k] = rresp_o; rd_last[k] = rlast_o; rd_id[k] = rid_o;
      @(negedge clk);
    end
    rready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_outs !== '0) $display("FAIL reset_outputs got=%h exp=0", all_outs);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({awready_o, arready_o} !== 2'b11)
      $display("FAIL idle_ready got aw=%b ar=%b exp 1 1", awready_o, arready_o);
    else n_pass++;
  endtask

  task automatic test_incr();
    logic [1:0] resp; logic [3:0] bid;
    logic [38:0] got, exp;
    clear_log();
    do_write(4'h3, 32'h0001_F100, 4'd15, 2'b01, 32'hA000_0000, resp, bid);
    n_checks++;
    if (log_addr.size() != 16) $display("FAIL incr_wr_count got=%0d exp=16", log_addr.size());
    else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (k >= log_addr.size())
        $display("FAIL incr_wr_beat%0d got no transfer exp addr=%h", k, 32'h0001_F100 + 32'(4*k));
      else if (log_addr[k] !== 32'h0001_F100 + 32'(4*k) || log_data[k] !== dpat(32'hA000_0000, k) ||
               log_wr[k] !== 1'b1 || log_sel[k] !== 2'b01)
        $display("FAIL incr_wr_beat%0d got addr=%h data=%h wr=%b sel=%b exp addr=%h data=%h wr=1 sel=01",
                 k, log_addr[k], log_data[k], log_wr[k], log_sel[k],
                 32'h0001_F100 + 32'(4*k), dpat(32'hA000_0000, k));
      else n_pass++;
    end
    n_checks++;
    if ({resp, bid} !== {2'b00, 4'h3}) $display("FAIL incr_bresp got resp=%b id=%h exp 00 3", resp, bid);
    else n_pass++;

    clear_log();
    do_read(4'h5, 32'h0001_F100, 4'd15, 2'b01);
    for (int k = 0; k < 16; k++) begin
      got = {rd_data[k], rd_resp[k], rd_last[k], rd_id[k]};
      exp = {dpat(32'hA000_0000, k), 2'b00, (k == 15), 4'h5};
      n_checks++;
      if (got !== exp) $display("FAIL incr_rd_beat%0d got {data,resp,last,id}=%h exp=%h", k, got, exp);
      else n_pass++;
    end
    n_checks++;
    if (log_addr.size() != 16 || log_wr[0] !== 1'b0 || log_addr[15] !== 32'h0001_F13C)
      $display("FAIL incr_rd_apb got count=%0d exp 16 reads ending at 0001f13c", log_addr.size());
    else n_pass++;
  endtask

  task automatic test_fixed();
    logic [1:0] resp; logic [3:0] bid;
    logic [34:0] got, exp;
    clear_log();
    do_write(4'h7, 32'h0002_F200, 4'd3, 2'b00, 32'hB000_0000, resp, bid);
    n_checks++;
    if (log_addr.size() != 4) $display("FAIL fixed_wr_count got=%0d exp=4", log_addr.size());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= log_addr.size())
        $display("FAIL fixed_wr_beat%0d got no transfer exp addr=0002f200", k);
      else if (log_addr[k] !== 32'h0002_F200 || log_data[k] !== dpat(32'hB000_0000, k) ||
               log_sel[k] !== 2'b10 || log_wr[k] !== 1'b1)
        $display("FAIL fixed_wr_beat%0d got addr=%h data=%h sel=%b exp addr=0002f200 data=%h sel=10",
                 k, log_addr[k], log_data[k], log_sel[k], dpat(32'hB000_0000, k));
      else n_pass++;
    end
    n_checks++;
    if (resp !== 2'b00) $display("FAIL fixed_bresp got=%b exp=00", resp);
    else n_pass++;

    do_read(4'h1, 32'h0002_F200, 4'd3, 2'b00);
    for (int k = 0; k < 4; k++) begin
      got = {rd_data[k], rd_resp[k], rd_last[k]};
      exp = {32'hB000_0333, 2'b00, (k == 3)};
      n_checks++;
      if (got !== exp) $display("FAIL fixed_rd_beat%0d got {data,resp,last}=%h exp=%h", k, got, exp);
      else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    logic [1:0] resp; logic [3:0] bid;
    wait_cfg = 3;
    clear_log();
    do_write(4'h2, 32'h0001_F400, 4'd0, 2'b01, 32'h1234_5678, resp, bid);
    n_checks++;
    if (log_pen.size() != 1 || log_pen[0] != 4 || log_stable[0] !== 1'b1 || resp !== 2'b00)
      $display("FAIL wait_wr got count=%0d penable_cycles=%0d stable=%b resp=%b exp 1 4 1 00",
               log_pen.size(), (log_pen.size() > 0) ? log_pen[0] : -1,
               (log_stable.size() > 0) ? log_stable[0] : 1'bx, resp);
    else n_pass++;
    clear_log();
    do_read(4'h2, 32'h0001_F400, 4'd0, 2'b01);
    n_checks++;
    if (rd_data[0] !== 32'h1234_5678 || rd_last[0] !== 1'b1 || rd_resp[0] !== 2'b00)
      $display("FAIL wait_rd_data got data=%h last=%b resp=%b exp 12345678 1 00",
               rd_data[0], rd_last[0], rd_resp[0]);
    else n_pass++;
    n_checks++;
    if (log_pen.size() != 1 || log_pen[0] != 4 || log_stable[0] !== 1'b1)
      $display("FAIL wait_rd_penable got count=%0d cycles=%0d exp 1 4",
               log_pen.size(), (log_pen.size() > 0) ? log_pen[0] : -1);
    else n_pass++;
    wait_cfg = 0;
  endtask

  task automatic test_slverr();
    logic [1:0] resp; logic [3:0] bid;
    clear_log();
    err_at = 1;
    do_write(4'h4, 32'h0001_F800, 4'd2, 2'b01, 32'hC000_0000, resp, bid);
    n_checks++;
    if (resp !== 2'b10 || log_addr.size() != 3)
      $display("FAIL slverr_bresp got resp=%b count=%0d exp 10 3", resp, log_addr.size());
    else n_pass++;
    clear_log();
    err_at = 1;
    do_read(4'h4, 32'h0001_F800, 4'd2, 2'b01);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (rd_resp[k] !== ((k == 1) ? 2'b10 : 2'b00) || rd_data[k] !== dpat(32'hC000_0000, k))
        $display("FAIL slverr_rd_beat%0d got resp=%b data=%h exp resp=%b data=%h", k, rd_resp[k],
                 rd_data[k], (k == 1) ? 2'b10 : 2'b00, dpat(32'hC000_0000, k));
      else n_pass++;
    end
    err_at = -1;
  endtask

  task automatic test_decode();
    logic [1:0] resp; logic [3:0] bid;
    clear_log();
    do_write(4'h6, 32'h0003_0000, 4'd0, 2'b01, 32'hD000_0000, resp, bid);
    n_checks++;
    if (resp !== 2'b11 || log_addr.size() != 0 || sel_seen !== 1'b0)
      $display("FAIL decerr_wr got resp=%b count=%0d psel_seen=%b exp 11 0 0", resp, log_addr.size(), sel_seen);
    else n_pass++;
    do_read(4'h6, 32'h0003_0000, 4'd0, 2'b01);
    n_checks++;
    if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'b11 || rd_last[0] !== 1'b1 || sel_seen !== 1'b0)
      $display("FAIL decerr_rd got data=%h resp=%b last=%b psel_seen=%b exp 0 11 1 0",
               rd_data[0], rd_resp[0], rd_last[0], sel_seen);
    else n_pass++;
    // Window edges: last word of slave 0 maps, first word past it and the
    // word just below slave 0 do not.
    clear_log();
    do_write(4'h0, 32'h0001_FFFC, 4'd0, 2'b01, 32'hE000_0000, resp, bid);
    n_checks++;
    if (resp !== 2'b00 || log_sel.size() != 1 || log_sel[0] !== 2'b01)
      $display("FAIL edge_top_in got resp=%b count=%0d exp 00 1 (psel 01)", resp, log_sel.size());
    else n_pass++;
    clear_log();
    do_write(4'h0, 32'h0002_0000, 4'd0, 2'b01, 32'hE000_0000, resp, bid);
    n_checks++;
    if (resp !== 2'b11 || log_addr.size() != 0)
      $display("FAIL edge_top_out got resp=%b count=%0d exp 11 0", resp, log_addr.size());
    else n_pass++;
    do_write(4'h0, 32'h0001_EFFC, 4'd0, 2'b01, 32'hE000_0000, resp, bid);
    n_checks++;
    if (resp !== 2'b11 || log_addr.size() != 0)
      $display("FAIL edge_bottom_out got resp=%b count=%0d exp 11 0", resp, log_addr.size());
    else n_pass++;
    // Burst running off the end of slave 0: beat 0 transfers, beat 1 is dropped.
    clear_log();
    do_write(4'h0, 32'h0001_FFFC, 4'd1, 2'b01, 32'hE100_0000, resp, bid);
    n_checks++;
    if (resp !== 2'b11 || log_addr.size() != 1)
      $display("FAIL edge_cross got resp=%b count=%0d exp 11 1", resp, log_addr.size());
    else n_pass++;
  endtask

  task automatic test_priority();
    int g;
    logic early_r;
    clear_log();
    early_r = 1'b0;
    awid_i = 4'h1; awaddr_i = 32'h0001_F000; awlen_i = 4'd0; awburst_i = 2'b01; awvalid_i = 1'b1;
    arid_i = 4'h2; araddr_i = 32'h0002_F200; arlen_i = 4'd0; arburst_i = 2'b00; arvalid_i = 1'b1;
    g = 0;
    while (!awready_o && g < 200) begin @(negedge clk); g++; end
    @(negedge clk);
    awvalid_i = 1'b0;
    wdata_i = 32'h5555_0000; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
    g = 0;
    while (!wready_o && g < 200) begin
      if (rvalid_o) early_r = 1'b1;
      @(negedge clk); g++;
    end
    @(negedge clk);
    wvalid_i = 1'b0;
    bready_i = 1'b1;
    g = 0;
    while (!bvalid_o && g < 200) begin
      if (rvalid_o) early_r = 1'b1;
      @(negedge clk); g++;
    end
    n_checks++;
    if (bvalid_o !== 1'b1 || bresp_o !== 2'b00 || bid_o !== 4'h1 || early_r !== 1'b0 ||
        log_addr.size() != 1 || log_wr[0] !== 1'b1)
      $display("FAIL prio_write_first got bvalid=%b resp=%b id=%h early_r=%b apb_count=%0d exp 1 00 1 0 1",
               bvalid_o, bresp_o, bid_o, early_r, log_addr.size());
    else n_pass++;
    @(negedge clk);
    bready_i = 1'b0;
    g = 0;
    while (!arready_o && g < 200) begin @(negedge clk); g++; end
    @(negedge clk);
    arvalid_i = 1'b0;
    rready_i  = 1'b1;
    g = 0;
    while (!rvalid_o && g < 200) begin @(negedge clk); g++; end
    n_checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'hB000_0333 || rid_o !== 4'h2 ||
        log_addr.size() != 2 || log_wr[1] !== 1'b0 || log_addr[1] !== 32'h0002_F200)
      $display("FAIL prio_read_after got rvalid=%b data=%h id=%h apb_count=%0d exp 1 b0000333 2 2",
               rvalid_o, rdata_o, rid_o, log_addr.size());
    else n_pass++;
    @(negedge clk);
    rready_i = 1'b0;
    n_checks++;
    if (mem.exists(32'h0001_F000) == 0 || mem[32'h0001_F000] !== 32'h5555_0000)
      $display("FAIL prio_wdata got written=%0d exp 55550000 at 0001f000", mem.exists(32'h0001_F000));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int g;
    logic resp_seen;
    clear_log();
    wait_cfg = 10;
    arid_i = 4'h9; araddr_i = 32'h0001_F100; arlen_i = 4'd3; arburst_i = 2'b01; arvalid_i = 1'b1;
    g = 0;
    while (!arready_o && g < 200) begin @(negedge clk); g++; end
    @(negedge clk);
    arvalid_i = 1'b0;
    rready_i  = 1'b1;
    g = 0;
    while (!penable_o && g < 200) begin @(negedge clk); g++; end
    n_checks++;
    if (penable_o !== 1'b1 || psel_o !== 2'b01)
      $display("FAIL rstmid_in_access got penable=%b psel=%b exp 1 01", penable_o, psel_o);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (all_outs !== '0) $display("FAIL rstmid_outputs got=%h exp=0", all_outs);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    wait_cfg = 0;
    resp_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rvalid_o || bvalid_o || psel_o != 2'b00) resp_seen = 1'b1;
    end
    rready_i = 1'b0;
    n_checks++;
    if (resp_seen !== 1'b0 || awready_o !== 1'b1 || log_addr.size() != 0)
      $display("FAIL rstmid_abort got activity=%b awready=%b apb_count=%0d exp 0 1 0",
               resp_seen, awready_o, log_addr.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_incr();
    test_fixed();
    test_wait_states();
    test_slverr();
    test_decode();
    test_priority();
    test_reset_mid();
    n_checks++;
    if (sel11_seen !== 1'b0) $display("FAIL psel_onehot got psel=11 seen exp never");
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
